// File: rtl/da_mac_if.sv
// -----------------------------------------------------------------------------
// da_mac_if
// Streaming handshake bundle for the bit-serial DA sum-of-products engine.
//   in_valid  : producer -> engine, x_in holds a valid sample set
//   in_ready  : engine -> producer, sample set accepted this cycle
//   x_in      : producer -> engine, packed samples, x[k] = x_in[k*XW +: XW]
//   out_valid : engine -> consumer, y holds a valid result
//   out_ready : consumer -> engine, consumer takes y this cycle
//   y         : engine -> consumer, signed result, YW bits
//   busy      : engine status, high while an operation is in flight
// Modports: master = producer/consumer side, slave = engine side.
// -----------------------------------------------------------------------------
interface da_mac_if #(
  parameter int TAPS = 3,
  parameter int XW   = 3,
  parameter int CW   = 4,
  localparam int YW  = CW + XW + $clog2(TAPS) + 1
);
  logic                 in_valid;
  logic                 in_ready;
  logic [TAPS*XW-1:0]   x_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [YW-1:0]        y;
  logic                 busy;

  modport master (
    output in_valid, x_in, out_ready,
    input  in_ready, out_valid, y, busy
  );

  modport slave (
    input  in_valid, x_in, out_ready,
    output in_ready, out_valid, y, busy
  );
endinterface

// File: rtl/da_mac_fsm.sv
// -----------------------------------------------------------------------------
// da_mac_fsm
// Bit-serial distributed-arithmetic sum-of-products: y = sum_k C[k]*x[k].
// One bit-plane per clock, LSB first; XW cycles per result. Coefficients are
// fixed at elaboration and the partial-product table is formed from them as a
// small combinational adder over the current bit-plane.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-high
//   bus   : da_mac_if.slave (in_valid/in_ready/x_in, out_valid/out_ready/y, busy)
// -----------------------------------------------------------------------------
module da_mac_fsm #(
  parameter int                 TAPS   = 3,
  parameter int                 XW     = 3,
  parameter int                 CW     = 4,
  parameter logic [TAPS*CW-1:0] COEFFS = {4'd1, 4'd3, 4'd2},
  parameter int                 SIGNED = 1,
  localparam int                YW     = CW + XW + $clog2(TAPS) + 1
) (
  input  logic      clk,
  input  logic      reset,
  da_mac_if.slave   bus
);

  // Table output width: enough for the sum of TAPS signed coefficients.
  localparam int TW   = CW + $clog2(TAPS) + 1;
  localparam int CNTW = $clog2(XW);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 r_state;
  logic [XW-1:0]          r_x [TAPS];
  logic signed [YW-1:0]   r_acc;
  logic signed [YW-1:0]   r_y;
  logic [CNTW-1:0]        r_cnt;
  logic                   r_in_ready;
  logic                   r_out_valid;
  logic                   r_busy;

  logic                   w_accept;
  logic                   w_consume;
  logic                   w_last;
  logic [TAPS-1:0]        w_addr;
  logic signed [TW-1:0]   w_coef [TAPS];
  logic signed [TW-1:0]   w_lut;
  logic signed [YW-1:0]   w_term;
  logic signed [YW-1:0]   w_acc_next;

  assign w_accept  = (r_state == ST_IDLE) && r_in_ready && bus.in_valid;
  assign w_consume = (r_state == ST_DONE) && r_out_valid && bus.out_ready;
  assign w_last    = (r_cnt == CNTW'(XW - 1));

  // Per-tap: sign-extended coefficient, table address bit, and the
  // sample shift register (LSB is the current bit-plane).
  generate
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
      localparam logic [CW-1:0] C_K = COEFFS[gi*CW +: CW];

      assign w_coef[gi] = {{(TW-CW){C_K[CW-1]}}, C_K};
      assign w_addr[gi] = r_x[gi][0];

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_x[gi] <= '0;
        end else if (w_accept) begin
          r_x[gi] <= bus.x_in[gi*XW +: XW];
        end else if (r_state == ST_RUN) begin
          r_x[gi] <= r_x[gi] >> 1;
        end
      end
    end
  endgenerate

  // Partial-product table: sum of coefficients whose address bit is set.
  always_comb begin
    w_lut = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (w_addr[k]) begin
        w_lut = w_lut + w_coef[k];
      end
    end
  end

  // Weight the table output by 2^j; the MSB plane of a two's-complement
  // input carries negative weight, so it is subtracted instead of added.
  assign w_term     = {{(YW-TW){w_lut[TW-1]}}, w_lut} << r_cnt;
  assign w_acc_next = ((SIGNED != 0) && w_last) ? (r_acc - w_term)
                                                : (r_acc + w_term);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_acc       <= '0;
      r_y         <= '0;
      r_cnt       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_acc      <= '0;
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= ST_RUN;
          end
        end

        ST_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_y         <= w_acc_next;
            r_out_valid <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Release to IDLE only; a new set is taken no earlier than the
          // following cycle, so there is no accept/consume bypass.
          if (w_consume) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state     <= ST_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.y         = r_y;
  assign bus.busy      = r_busy;

endmodule
